// File: rtl/mem_wb_buffer_pkg.sv
// rtl/mem_wb_buffer_pkg.sv - shared writeback request type and buffer defaults
package mem_wb_buffer_pkg;

   localparam int MEM_WB_DEPTH        = 4;
   localparam int MEM_WB_STARVE_LIMIT = 8;

   localparam int RD_W   = 5;
   localparam int DATA_W = 32;
   localparam int ROB_W  = 5;

   // One writeback request; valid doubles as the push request on the input side.
   typedef struct packed {
      logic              valid;
      logic [RD_W-1:0]   rd;
      logic [DATA_W-1:0] data;
      logic [ROB_W-1:0]  rob_idx;
   } wb_req_t;

endpackage

// File: rtl/mem_wb_buffer_if.sv
// rtl/mem_wb_buffer_if.sv - producer/arbiter side bundle of the writeback buffer
interface mem_wb_buffer_if
   import mem_wb_buffer_pkg::*;
#(
   parameter int DEPTH = MEM_WB_DEPTH
) ();

   wb_req_t              i_req;
   logic                 o_ready;
   wb_req_t              o_req;
   logic                 i_grant;
   logic                 i_flush;
   logic [$clog2(DEPTH):0] o_count;
   logic                 o_starve;

   // Environment side: producer pushes, arbiter grants, pipeline flushes.
   modport master (
      output i_req, i_grant, i_flush,
      input  o_ready, o_req, o_count, o_starve
   );

   // Buffer side.
   modport slave (
      input  i_req, i_grant, i_flush,
      output o_ready, o_req, o_count, o_starve
   );

endinterface

// File: rtl/mem_wb_buffer_starve_counter.sv
// rtl/mem_wb_buffer_starve_counter.sv - saturating wait counter for an ungranted head
module wb_starve_counter #(
   parameter int LIMIT = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_valid,
   input  logic i_grant,
   input  logic i_clear,
   output logic o_starve
);

   localparam int             W       = $clog2(LIMIT + 1);
   localparam logic [W-1:0]   LIMIT_W = W'(LIMIT);

   logic [W-1:0] wait_q;
   logic [W-1:0] wait_d;

   // Count cycles the head sits ungranted; restart whenever it leaves or the buffer empties.
   always_comb begin
      wait_d = wait_q;
      if (i_clear || !i_valid) begin
         wait_d = '0;
      end else if (!i_grant && (wait_q != LIMIT_W)) begin
         wait_d = wait_q + W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   // Derived only from the register, so grant cannot glitch it.
   assign o_starve = (wait_q == LIMIT_W);

endmodule

// File: rtl/mem_wb_buffer.sv
// rtl/mem_wb_buffer.sv - in-order FIFO of load/multiplier results awaiting writeback
module mem_wb_buffer
   import mem_wb_buffer_pkg::*;
#(
   parameter int DEPTH        = MEM_WB_DEPTH,
   parameter int STARVE_LIMIT = MEM_WB_STARVE_LIMIT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mem_wb_buffer_if.slave    bus
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam int              CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             not_empty;
   logic             push;
   logic             pop;

   assign not_empty = (count_q != '0);
   // Ready ignores a same-cycle pop so it depends only on registered state.
   assign bus.o_ready = (count_q != DEPTH_C);
   assign push = bus.i_req.valid && bus.o_ready && !bus.i_flush;
   assign pop  = not_empty && bus.i_grant && !bus.i_flush;

   // Pointer and occupancy update; flush wins over push and pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.i_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage, deliberately not reset.
   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bus.i_req;
      end
   end

   // Head entry straight from storage; a pushed entry is seen the cycle after its push.
   always_comb begin
      bus.o_req       = mem_q[rd_ptr_q];
      bus.o_req.valid = mem_q[rd_ptr_q].valid && not_empty;
   end

   assign bus.o_count = count_q;

   wb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_valid  (not_empty),
      .i_grant  (bus.i_grant),
      .i_clear  (pop || bus.i_flush),
      .o_starve (bus.o_starve)
   );

   // A refused request must be held unchanged until it is accepted or flushed.
   property p_hold_while_not_ready;
      @(posedge i_clk) disable iff (!i_rst_n)
         (bus.i_req.valid && !bus.o_ready && !bus.i_flush)
            |=> (bus.i_req.valid && (bus.i_req == $past(bus.i_req)));
   endproperty
   a_hold_while_not_ready: assert property (p_hold_while_not_ready);

endmodule
